// File: rtl/pc_unit.sv
// Program counter with prioritised branch/jump redirects. A redirect that arrives during a stall
// is buffered and applied on the first unstalled edge. Also tracks redirect count and misalignment.
module pc_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             j_instr,
  input  logic [WIDTH-1:0] j_target,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] pc_plus8,
  output logic             flush,
  output logic             misalign,
  output logic             pending,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [WIDTH-1:0] ResetPc = WIDTH'(RESET_PC);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pending_q, pending_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             req;
  logic [WIDTH-1:0] req_target;
  logic [WIDTH-1:0] req_aligned;
  logic             req_misaligned;
  logic             load_redirect;

  always_comb begin
    req = br_taken | j_instr | jr;
    if (br_taken) begin
      req_target = br_target;
    end else if (j_instr) begin
      req_target = j_target;
    end else begin
      req_target = jr_target;
    end
    req_aligned    = {req_target[WIDTH-1:2], 2'b00};
    req_misaligned = |req_target[1:0];
  end

  always_comb begin
    pc_d          = pc_q;
    pend_tgt_d    = pend_tgt_q;
    pending_d     = pending_q;
    misalign_d    = misalign_q;
    load_redirect = 1'b0;
    if (!stall) begin
      // A fresh request overrides anything buffered; the buffer is consumed either way.
      pending_d = 1'b0;
      if (req) begin
        pc_d          = req_aligned;
        load_redirect = 1'b1;
        misalign_d    = misalign_q | req_misaligned;
      end else if (pending_q) begin
        pc_d          = pend_tgt_q;
        load_redirect = 1'b1;
      end else begin
        pc_d = pc_q + WIDTH'(32'd4);
      end
    end else if (req) begin
      pending_d  = 1'b1;
      pend_tgt_d = req_aligned;
      misalign_d = misalign_q | req_misaligned;
    end
    flush_d = load_redirect;
    cnt_d   = (load_redirect && (cnt_q != CntMax)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= ResetPc;
      pend_tgt_q <= '0;
      pending_q  <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pending_q  <= pending_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc           = pc_q;
  assign pc_plus4     = pc_q + WIDTH'(32'd4);
  assign pc_plus8     = pc_q + WIDTH'(32'd8);
  assign flush        = flush_q;
  assign misalign     = misalign_q;
  assign pending      = pending_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: a default 32-bit instance and a narrow
// WIDTH=8 / CNT_W=2 instance for wrap, saturation and reset-during-stall cases.
module tb_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance signals
  logic        rst_n, stall, br, jp, jr;
  logic [31:0] br_t, j_t, jr_t;
  logic [31:0] pc, pc4, pc8;
  logic        flush, misalign, pending;
  logic [15:0] cnt;

  // Narrow instance signals
  logic       rst8_n, stall8, br8, jp8, jr8;
  logic [7:0] br8_t, j8_t, jr8_t;
  logic [7:0] pc_n, pc4_n, pc8_n;
  logic       flush_n, misalign_n, pending_n;
  logic [1:0] cnt_n;

  pc_unit dut (
    .clk          (clk),
    .reset        (rst_n),
    .stall        (stall),
    .br_taken     (br),
    .br_target    (br_t),
    .j_instr      (jp),
    .j_target     (j_t),
    .jr           (jr),
    .jr_target    (jr_t),
    .pc           (pc),
    .pc_plus4     (pc4),
    .pc_plus8     (pc8),
    .flush        (flush),
    .misalign     (misalign),
    .pending      (pending),
    .redirect_cnt (cnt)
  );

  pc_unit #(
    .WIDTH    (8),
    .RESET_PC (32'h0000_00FC),
    .CNT_W    (2)
  ) dut8 (
    .clk          (clk),
    .reset        (rst8_n),
    .stall        (stall8),
    .br_taken     (br8),
    .br_target    (br8_t),
    .j_instr      (jp8),
    .j_target     (j8_t),
    .jr           (jr8),
    .jr_target    (jr8_t),
    .pc           (pc_n),
    .pc_plus4     (pc4_n),
    .pc_plus8     (pc8_n),
    .flush        (flush_n),
    .misalign     (misalign_n),
    .pending      (pending_n),
    .redirect_cnt (cnt_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; br = 1'b0; jp = 1'b0; jr = 1'b0;
    br_t = '0; j_t = '0; jr_t = '0;
    rst8_n = 1'b0; stall8 = 1'b0; br8 = 1'b0; jp8 = 1'b0; jr8 = 1'b0;
    br8_t = '0; j8_t = '0; jr8_t = '0;
    tick();
    tick();

    check("rst_pc", pc, 32'h3000);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_pending", {31'b0, pending}, 32'd0);
    check("rst_cnt", {16'b0, cnt}, 32'd0);

    rst_n = 1'b1;
    tick(); check("seq_pc1", pc, 32'h3004);
    tick(); check("seq_pc2", pc, 32'h3008);
    tick(); check("seq_pc3", pc, 32'h300C);
    check("seq_plus8", pc8, 32'h3014);
    check("seq_plus4", pc4, 32'h3010);
    tick(); check("seq_pc4", pc, 32'h3010);

    // All three requests together: branch has priority
    br = 1'b1; br_t = 32'h3100;
    jp = 1'b1; j_t  = 32'h3200;
    jr = 1'b1; jr_t = 32'h3300;
    tick();
    br = 1'b0; jp = 1'b0; jr = 1'b0;
    check("prio_pc", pc, 32'h3100);
    check("prio_flush", {31'b0, flush}, 32'd1);
    check("prio_cnt", {16'b0, cnt}, 32'd1);
    tick();
    check("prio_pc_next", pc, 32'h3104);
    check("prio_flush_drop", {31'b0, flush}, 32'd0);

    // Two requests under stall: latest wins
    stall = 1'b1;
    jp = 1'b1; j_t = 32'h3400;
    tick();
    jp = 1'b0;
    check("stall_hold1", pc, 32'h3104);
    check("stall_pend1", {31'b0, pending}, 32'd1);
    check("stall_flush", {31'b0, flush}, 32'd0);
    jr = 1'b1; jr_t = 32'h3500;
    tick();
    jr = 1'b0;
    check("stall_hold2", pc, 32'h3104);
    tick();
    check("stall_hold3", pc, 32'h3104);
    check("stall_pend3", {31'b0, pending}, 32'd1);
    stall = 1'b0;
    tick();
    check("drain_pc", pc, 32'h3500);
    check("drain_pend", {31'b0, pending}, 32'd0);
    check("drain_flush", {31'b0, flush}, 32'd1);
    check("drain_cnt", {16'b0, cnt}, 32'd2);

    // Fresh request beats the buffered one
    stall = 1'b1;
    jr = 1'b1; jr_t = 32'h3500;
    tick();
    jr = 1'b0;
    check("ovr_pend", {31'b0, pending}, 32'd1);
    stall = 1'b0;
    br = 1'b1; br_t = 32'h3600;
    tick();
    br = 1'b0;
    check("ovr_pc", pc, 32'h3600);
    check("ovr_pend_clr", {31'b0, pending}, 32'd0);
    check("ovr_cnt", {16'b0, cnt}, 32'd3);
    tick();
    check("ovr_pc_next", pc, 32'h3604);

    // Misaligned register jump
    jr = 1'b1; jr_t = 32'h3007;
    tick();
    jr = 1'b0;
    check("mis_pc", pc, 32'h3004);
    check("mis_flag", {31'b0, misalign}, 32'd1);
    for (int i = 0; i < 10; i++) tick();
    check("mis_pc_after", pc, 32'h302C);
    check("mis_sticky", {31'b0, misalign}, 32'd1);

    // Narrow instance: wrap, saturation, reset during a buffered stall
    rst8_n = 1'b1;
    check("n_rst_pc", {24'b0, pc_n}, 32'hFC);
    check("n_plus4_wrap", {24'b0, pc4_n}, 32'h00);
    check("n_plus8_wrap", {24'b0, pc8_n}, 32'h04);
    tick();
    check("n_wrap_pc", {24'b0, pc_n}, 32'h00);
    br8 = 1'b1; br8_t = 8'h10;
    for (int i = 0; i < 5; i++) tick();
    br8 = 1'b0;
    check("n_sat_cnt", {30'b0, cnt_n}, 32'd3);
    check("n_sat_pc", {24'b0, pc_n}, 32'h10);
    stall8 = 1'b1;
    jr8 = 1'b1; jr8_t = 8'h21;
    tick();
    jr8 = 1'b0;
    check("n_pend", {31'b0, pending_n}, 32'd1);
    check("n_pend_mis", {31'b0, misalign_n}, 32'd1);
    check("n_hold_pc", {24'b0, pc_n}, 32'h10);
    rst8_n = 1'b0;
    #1;
    check("n_arst_pc", {24'b0, pc_n}, 32'hFC);
    check("n_arst_pend", {31'b0, pending_n}, 32'd0);
    check("n_arst_mis", {31'b0, misalign_n}, 32'd0);
    check("n_arst_cnt", {30'b0, cnt_n}, 32'd0);
    check("n_arst_flush", {31'b0, flush_n}, 32'd0);
    #2;
    rst8_n = 1'b1;
    stall8 = 1'b0;
    tick();
    check("n_post_pc", {24'b0, pc_n}, 32'h00);
    check("n_post_flush", {31'b0, flush_n}, 32'd0);
    check("n_post_cnt", {30'b0, cnt_n}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32, sets the width of the PC and of every target input.
REQ-002 Parameter RESET_PC, default 32'h0000_3000 (truncated to WIDTH), sets the PC value after reset.
REQ-003 Parameter CNT_W, default 16, sets the width of the redirect counter.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  1 = hold the PC this cycle.
REQ-007 br_taken  input  1  branch resolved taken; single-cycle event.
REQ-008 br_target  input  WIDTH  branch target address.
REQ-009 j_instr  input  1  direct jump; single-cycle event.
REQ-010 j_target  input  WIDTH  jump target address.
REQ-011 jr  input  1  register jump; single-cycle event.
REQ-012 jr_target  input  WIDTH  forwarded register value (jump target).
REQ-013 pc  output  WIDTH  current fetch address (registered).
REQ-014 pc_plus4  output  WIDTH  pc + 4, combinational, modulo 2^WIDTH.
REQ-015 pc_plus8  output  WIDTH  pc + 8, combinational, modulo 2^WIDTH.
REQ-016 flush  output  1  high for one cycle after any redirect is loaded into pc.
REQ-017 misalign  output  1  sticky flag: some loaded target had bits [1:0] != 0.
REQ-018 pending  output  1  a redirect is buffered behind a stall.
REQ-019 redirect_cnt  output  CNT_W  saturating count of redirects loaded into pc.

Function
REQ-020 The redirect request in a cycle SHALL use fixed priority: br_taken > j_instr > jr; the selected target is req_target, and req = br_taken | j_instr | jr.
REQ-021 When stall = 0 and req = 1, pc SHALL load req_target with bits [1:0] forced to 0 on the next edge.
REQ-022 When stall = 0, req = 0 and pending = 1, pc SHALL load the buffered target and pending SHALL clear on the same edge.
REQ-023 When stall = 0, req = 1 and pending = 1, the current req_target SHALL win; pending SHALL clear and the buffered target is discarded.
REQ-024 When stall = 0, req = 0 and pending = 0, pc SHALL load pc + 4 modulo 2^WIDTH; pc = 2^WIDTH-4 wraps to 0.
REQ-025 When stall = 1, pc SHALL hold its value.
REQ-026 When stall = 1 and req = 1, req_target SHALL be written to the pending buffer and pending SHALL set; a later request under stall overwrites the buffer (latest wins).
REQ-027 When stall = 1 and req = 0, the pending buffer and the pending flag SHALL hold their values.
REQ-028 flush SHALL be 1 in the cycle following every edge on which pc loaded a redirect (REQ-021 or REQ-022) and 0 otherwise, including during stalls.
REQ-029 misalign SHALL set on the edge a target with bits [1:0] != 0 is loaded into pc, or written to the pending buffer, and SHALL stay set until reset.
REQ-030 redirect_cnt SHALL increment by 1 on each edge where pc loads a redirect, and SHALL saturate at 2^CNT_W-1.
REQ-031 Latency: a redirect accepted with stall = 0 SHALL appear on pc exactly one cycle later; a buffered redirect SHALL appear one cycle after the first cycle in which stall = 0.

Reset
REQ-032 While reset = 0, outputs SHALL be forced asynchronously to: pc = RESET_PC, flush = 0, misalign = 0, pending = 0, redirect_cnt = 0, and pending buffer = 0.
REQ-033 If reset asserts while a request is buffered, the buffered request SHALL be lost; after reset releases, the first enabled edge SHALL load RESET_PC + 4.
REQ-034 Reset release SHALL take effect on the first rising clk edge after reset = 1; there is no extra synchronisation stage inside the block.

Verification
REQ-035 Reset, then 3 unstalled cycles with no request -> pc = 0x3000, 0x3004, 0x3008, 0x300C; pc_plus8 = 0x3014 at the last step.
REQ-036 At pc = 0x3010, assert br_taken, j_instr and jr together with targets 0x3100, 0x3200 and 0x3300 -> next pc = 0x3100; flush = 1 for one cycle; redirect_cnt = 1.
REQ-037 With stall = 1, apply a j_instr pulse to 0x3400, then a jr pulse to 0x3500 -> pc held, pending = 1; release stall with no request -> pc = 0x3500, pending = 0, flush = 1.
REQ-038 With pending holding 0x3500, release stall with br_taken = 1 and target 0x3600 -> pc = 0x3600, pending = 0, redirect_cnt increments by 1 only.
REQ-039 Apply jr with jr_target 0x3007 -> pc = 0x3004 and misalign = 1; then 10 normal cycles -> misalign stays 1.
REQ-040 WIDTH = 8, CNT_W = 2: pc = 0xFC with no request -> pc = 0x00; apply 5 redirects -> redirect_cnt = 3; pulse reset low mid-stall with pending = 1 -> all outputs return to reset values immediately.
